// File: rtl/clock_pkg.sv
// Shared types and BCD calendar helpers for the clock set controller.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_SET_YEAR  = 3'd1,
    ST_SET_MONTH = 3'd2,
    ST_SET_DAY   = 3'd3,
    ST_SET_HOUR  = 3'd4,
    ST_SET_MIN   = 3'd5,
    ST_COMMIT    = 3'd6
  } state_t;

  typedef logic [7:0]  bcd2_t;
  typedef logic [15:0] bcd4_t;

  localparam bcd2_t MONTH_JAN = 8'h01;
  localparam bcd2_t MONTH_FEB = 8'h02;
  localparam bcd2_t MONTH_APR = 8'h04;
  localparam bcd2_t MONTH_JUN = 8'h06;
  localparam bcd2_t MONTH_SEP = 8'h09;
  localparam bcd2_t MONTH_NOV = 8'h11;
  localparam bcd2_t MONTH_DEC = 8'h12;
  localparam bcd2_t MAX_HOUR  = 8'h23;
  localparam bcd2_t MAX_MIN   = 8'h59;

  function automatic bcd2_t bcd2_inc_wrap(bcd2_t v, bcd2_t max_v, bcd2_t wrap_v);
    bcd2_t r;
    if (v >= max_v) r = wrap_v;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic bcd4_t bcd4_inc(bcd4_t v);
    bcd4_t r;
    logic  carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] bcd2_bin(bcd2_t v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  // Century years are leap only when the century number is itself a multiple of 4.
  function automatic logic is_leap(bcd4_t y);
    logic [6:0] yy;
    logic [6:0] cc;
    yy = bcd2_bin(y[7:0]);
    cc = bcd2_bin(y[15:8]);
    return (yy[1:0] == 2'b00) && ((yy != 7'd0) || (cc[1:0] == 2'b00));
  endfunction

  function automatic bcd2_t days_in_month(bcd2_t month, bcd4_t year);
    bcd2_t d;
    case (month)
      MONTH_FEB:                                d = is_leap(year) ? 8'h29 : 8'h28;
      MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV: d = 8'h30;
      default:                                  d = 8'h31;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] blink_field(state_t s);
    logic [7:0] m;
    case (s)
      ST_SET_YEAR:              m = 8'h0F;
      ST_SET_MONTH, ST_SET_MIN: m = 8'h30;
      ST_SET_DAY, ST_SET_HOUR:  m = 8'hC0;
      default:                  m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/clock_set_controller_tick_gen.sv
// Free-running divider: pulse is high in the cycle the count wraps from DIV-1.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic pulse
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    pulse = 1'b0;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      pulse = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clock_set_controller.sv
// Button-driven date/time edit FSM with 1 Hz advance strobe and blink mask.
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic [15:0] cur_year,
  input  logic [7:0]  cur_month,
  input  logic [7:0]  cur_day,
  input  logic [7:0]  cur_hour,
  input  logic [7:0]  cur_min,
  output logic        tick_1hz,
  output logic        load,
  output logic [15:0] set_year,
  output logic [7:0]  set_month,
  output logic [7:0]  set_day,
  output logic [7:0]  set_hour,
  output logic [7:0]  set_min,
  output logic        editing,
  output logic        disp_mode,
  output logic [7:0]  blink_mask
);

  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BLINK_DIV  = (BLINK_HALF < 1) ? 1 : BLINK_HALF;

  state_t state_q, state_d;
  bcd4_t  year_q, year_d;
  bcd2_t  month_q, month_d, day_q, day_d, hour_q, hour_d, min_q, min_d;
  bcd2_t  day_max;
  logic   next_lvl_q, inc_lvl_q;
  logic   next_edge_q, next_edge_d, inc_edge_q, inc_edge_d;
  logic   phase_q, phase_d;
  logic   run_en, blink_clr, blink_pulse;

  always_comb begin
    next_edge_d = btn_next & ~next_lvl_q;
    inc_edge_d  = btn_inc & ~inc_lvl_q;
  end

  // A next edge always wins over a same-cycle inc edge.
  always_comb begin
    state_d = state_q;
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    hour_d  = hour_q;
    min_d   = min_q;
    day_max = days_in_month(month_q, year_q);
    case (state_q)
      ST_RUN: begin
        if (next_edge_q) begin
          state_d = ST_SET_YEAR;
          year_d  = cur_year;
          month_d = cur_month;
          day_d   = cur_day;
          hour_d  = cur_hour;
          min_d   = cur_min;
        end
      end
      ST_SET_YEAR: begin
        if (next_edge_q)     state_d = ST_SET_MONTH;
        else if (inc_edge_q) year_d  = bcd4_inc(year_q);
      end
      ST_SET_MONTH: begin
        if (next_edge_q) begin
          state_d = ST_SET_DAY;
          if (day_q > day_max) day_d = day_max;
        end else if (inc_edge_q) begin
          month_d = bcd2_inc_wrap(month_q, MONTH_DEC, MONTH_JAN);
        end
      end
      ST_SET_DAY: begin
        if (next_edge_q)     state_d = ST_SET_HOUR;
        else if (inc_edge_q) day_d   = bcd2_inc_wrap(day_q, day_max, 8'h01);
      end
      ST_SET_HOUR: begin
        if (next_edge_q)     state_d = ST_SET_MIN;
        else if (inc_edge_q) hour_d  = bcd2_inc_wrap(hour_q, MAX_HOUR, 8'h00);
      end
      ST_SET_MIN: begin
        if (next_edge_q)     state_d = ST_COMMIT;
        else if (inc_edge_q) min_d   = bcd2_inc_wrap(min_q, MAX_MIN, 8'h00);
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    load       = (state_q == ST_COMMIT);
    editing    = (state_q != ST_RUN) && (state_q != ST_COMMIT);
    disp_mode  = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);
    blink_mask = phase_q ? blink_field(state_q) : 8'h00;
    set_year   = year_q;
    set_month  = month_q;
    set_day    = day_q;
    set_hour   = hour_q;
    set_min    = min_q;
    run_en     = (state_q == ST_RUN);
  end

  // Phase 0 means "shown"; it restarts on every state entry and accepted inc.
  always_comb begin
    blink_clr = (state_d != state_q) || (inc_edge_q && editing);
    phase_d   = phase_q;
    if (blink_clr)        phase_d = 1'b0;
    else if (blink_pulse) phase_d = ~phase_q;
  end

  tick_gen #(.DIV(CLK_HZ)) u_tick_1hz (
    .clk   (clk),
    .rst   (rst),
    .en    (run_en),
    .clr   (~run_en),
    .pulse (tick_1hz)
  );

  tick_gen #(.DIV(BLINK_DIV)) u_tick_blink (
    .clk   (clk),
    .rst   (rst),
    .en    (editing),
    .clr   (blink_clr),
    .pulse (blink_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      year_q      <= '0;
      month_q     <= '0;
      day_q       <= '0;
      hour_q      <= '0;
      min_q       <= '0;
      next_lvl_q  <= 1'b0;
      inc_lvl_q   <= 1'b0;
      next_edge_q <= 1'b0;
      inc_edge_q  <= 1'b0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      year_q      <= year_d;
      month_q     <= month_d;
      day_q       <= day_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      next_lvl_q  <= btn_next;
      inc_lvl_q   <= btn_inc;
      next_edge_q <= next_edge_d;
      inc_edge_q  <= inc_edge_d;
      phase_q     <= phase_d;
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: calendar-level model, per-cycle compare, directed vectors.
module tb_clock_set_controller;

  localparam int CLK_HZ   = 10;
  localparam int BLINK_HZ = 2;
  localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_next = 1'b0;
  logic        btn_inc = 1'b0;
  logic [15:0] cur_year = '0;
  logic [7:0]  cur_month = '0, cur_day = '0, cur_hour = '0, cur_min = '0;
  logic        tick_1hz, load, editing, disp_mode;
  logic [15:0] set_year;
  logic [7:0]  set_month, set_day, set_hour, set_min, blink_mask;

  clock_set_controller #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_next   (btn_next),
    .btn_inc    (btn_inc),
    .cur_year   (cur_year),
    .cur_month  (cur_month),
    .cur_day    (cur_day),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .tick_1hz   (tick_1hz),
    .load       (load),
    .set_year   (set_year),
    .set_month  (set_month),
    .set_day    (set_day),
    .set_hour   (set_hour),
    .set_min    (set_min),
    .editing    (editing),
    .disp_mode  (disp_mode),
    .blink_mask (blink_mask)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  bit          started = 1'b0;
  logic [47:0] exp_q[$];
  logic [47:0] sb_exp;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- calendar model ----------------
  function automatic int from_bcd(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] to_bcd4(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic bit leap(input int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int dim(input int m, input int y);
    if (m == 2) return leap(y) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  // Model state numbering: 0 run, 1 year, 2 month, 3 day, 4 hour, 5 min, 6 commit.
  function automatic logic [7:0] fmask(input int s);
    case (s)
      1:       return 8'h0F;
      2, 5:    return 8'h30;
      3, 4:    return 8'hC0;
      default: return 8'h00;
    endcase
  endfunction

  int m_state = 0, m_year = 0, m_month = 0, m_day = 0, m_hour = 0, m_min = 0;
  int m_run = 0, m_blink = 0;
  bit m_next_prev = 0, m_inc_prev = 0, m_next_ev = 0, m_inc_ev = 0;

  always @(posedge clk) begin : model
    int old;
    bit in_edit;
    if (rst) begin
      m_state = 0; m_year = 0; m_month = 0; m_day = 0; m_hour = 0; m_min = 0;
      m_run = 0; m_blink = 0;
      m_next_prev = 0; m_inc_prev = 0; m_next_ev = 0; m_inc_ev = 0;
    end else begin
      old     = m_state;
      in_edit = (old >= 1) && (old <= 5);
      if (old == 6) begin
        m_state = 0;
      end else if (m_next_ev) begin
        if (old == 0) begin
          m_year = from_bcd(cur_year);  m_month = from_bcd({8'h00, cur_month});
          m_day = from_bcd({8'h00, cur_day}); m_hour = from_bcd({8'h00, cur_hour});
          m_min = from_bcd({8'h00, cur_min});
        end
        m_state = old + 1;
        if (m_state == 3 && m_day > dim(m_month, m_year)) m_day = dim(m_month, m_year);
      end else if (m_inc_ev && in_edit) begin
        case (old)
          1: m_year  = (m_year + 1) % 10000;
          2: m_month = (m_month == 12) ? 1 : m_month + 1;
          3: m_day   = (m_day >= dim(m_month, m_year)) ? 1 : m_day + 1;
          4: m_hour  = (m_hour + 1) % 24;
          default: m_min = (m_min + 1) % 60;
        endcase
      end
      if (m_state == 0) m_run = (old == 0) ? m_run + 1 : 0;
      if (m_state != old || (m_inc_ev && in_edit)) m_blink = 0;
      else m_blink++;
      if (m_state == 6)
        exp_q.push_back({to_bcd4(m_year), to_bcd2(m_month), to_bcd2(m_day),
                         to_bcd2(m_hour), to_bcd2(m_min)});
      m_next_ev = btn_next && !m_next_prev; m_next_prev = btn_next;
      m_inc_ev  = btn_inc && !m_inc_prev;   m_inc_prev  = btn_inc;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("tick_1hz", tick_1hz, (m_state == 0) && (m_run % CLK_HZ == CLK_HZ - 1));
      chk("load", load, m_state == 6);
      chk("editing", editing, (m_state >= 1) && (m_state <= 5));
      chk("disp_mode", disp_mode, (m_state == 4) || (m_state == 5));
      chk("blink_mask", blink_mask, ((m_blink / HALF) % 2 == 1) ? fmask(m_state) : 8'h00);
      chk("set_fields", {set_year, set_month, set_day, set_hour, set_min},
          {to_bcd4(m_year), to_bcd2(m_month), to_bcd2(m_day), to_bcd2(m_hour), to_bcd2(m_min)});
      if (load) begin
        sb_exp = '1;
        if (exp_q.size() != 0) sb_exp = exp_q.pop_front();
        chk("load_payload", {set_year, set_month, set_day, set_hour, set_min}, sb_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cur(input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                         input logic [7:0] h, input logic [7:0] mi);
    cur_year = y; cur_month = mo; cur_day = d; cur_hour = h; cur_min = mi;
  endtask

  task automatic press_next();
    btn_next = 1'b1; cycles(1); btn_next = 1'b0; cycles(2);
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; cycles(1); btn_inc = 1'b0; cycles(2);
  endtask

  task automatic wait_tick(output int d);
    d = 0;
    do begin
      @(negedge clk);
      d++;
    end while (!tick_1hz && d < 4 * CLK_HZ);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int d;
    set_cur(16'h2024, 8'h02, 8'h29, 8'h13, 8'h45);
    @(posedge clk); @(negedge clk);
    started = 1'b1;
    chk("rst_tick", tick_1hz, 1'b0);
    chk("rst_load", load, 1'b0);
    chk("rst_editing", editing, 1'b0);
    chk("rst_blink", blink_mask, 8'h00);
    chk("rst_set_year", set_year, 16'h0000);
    cycles(2);
    rst = 1'b0;
    wait_tick(d); chk("first_tick_cycle", d, 9);
    wait_tick(d); chk("tick_period", d, 10);

    // inc in RUN is ignored
    press_inc();
    chk("run_inc_ignored", editing, 1'b0);

    // snapshot and commit without edits
    press_next();
    cycles(1);
    chk("set_year_blink", blink_mask, 8'h0F);
    cur_year = 16'h1999;
    press_next(); press_next(); press_next();
    chk("hour_disp_clock", disp_mode, 1'b1);
    press_next();
    btn_next = 1'b1; cycles(1); btn_next = 1'b0; cycles(1);
    chk("commit_load", load, 1'b1);
    chk("commit_fields", {set_year, set_month, set_day, set_hour, set_min}, 48'h2024_02_29_13_45);
    wait_tick(d); chk("tick_after_commit", d, 10);

    // leap clamp and hour/minute wraps
    set_cur(16'h2024, 8'h02, 8'h29, 8'h23, 8'h59);
    press_next(); press_inc();
    chk("year_inc", set_year, 16'h2025);
    press_next(); press_next();
    chk("leap_clamp", set_day, 8'h28);
    press_inc();
    chk("day_wrap_28", set_day, 8'h01);
    press_next(); press_inc();
    chk("hour_wrap", set_hour, 8'h00);
    press_next(); press_inc();
    chk("min_wrap", set_min, 8'h00);
    press_next();

    // year/month wraps, simultaneous edges, held inc, reset mid-edit
    set_cur(16'h9999, 8'h12, 8'h31, 8'h08, 8'h30);
    press_next(); press_inc();
    chk("year_wrap", set_year, 16'h0000);
    press_next(); press_inc();
    chk("month_wrap", set_month, 8'h01);
    btn_next = 1'b1; btn_inc = 1'b1; cycles(1);
    btn_next = 1'b0; btn_inc = 1'b0; cycles(2);
    chk("simul_month_kept", set_month, 8'h01);
    cycles(1);
    chk("simul_in_day", blink_mask, 8'hC0);
    btn_inc = 1'b1; cycles(20); btn_inc = 1'b0; cycles(2);
    chk("held_inc_once", set_day, 8'h01);
    press_next();
    rst = 1'b1; cycles(1);
    chk("midrst_editing", editing, 1'b0);
    chk("midrst_blink", blink_mask, 8'h00);
    chk("midrst_load", load, 1'b0);
    rst = 1'b0; cycles(3);

    // century rules
    set_cur(16'h2100, 8'h02, 8'h29, 8'h10, 8'h10);
    press_next(); press_next(); press_next();
    chk("y2100_feb", set_day, 8'h28);
    press_next(); press_next(); press_next();
    set_cur(16'h2000, 8'h02, 8'h29, 8'h07, 8'h05);
    press_next(); press_next(); press_next();
    chk("y2000_feb", set_day, 8'h29);
    press_inc();
    chk("y2000_wrap", set_day, 8'h01);
    press_next(); press_next(); press_next();
    set_cur(16'h2023, 8'h02, 8'h31, 8'h00, 8'h00);
    press_next(); press_next(); press_next();
    chk("y2023_clamp31", set_day, 8'h28);
    press_next(); press_next(); press_next();
    cycles(12);

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
